// File: rtl/rr_mutex_arbiter.sv
// rr_mutex_arbiter
//   Clocked round-robin arbiter granting one shared resource to at most one of
//   N requesters at a time. A grant is held while the owner keeps its request
//   high, up to MAX_HOLD cycles (0 = unlimited). Every change of owner passes
//   through at least one all-zero grant cycle (RELEASE), even when the same
//   index is granted again.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   req      in   [N]    level-sensitive request vector
//   gnt      out  [N]    one-hot grant, zero when the resource is free
//   gnt_id   out  [IDW]  index of the current owner, 0 when gnt is zero
//   busy     out         high while any grant bit is high
//   timeout  out         one-cycle pulse in the RELEASE cycle of a forced release
module rr_mutex_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           timeout
);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("rr_mutex_arbiter: N must lie in 2..16");
  end

  // A zero-width counter is not legal, so keep one bit when the limit is off.
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic           busy_q, busy_d;
  logic           timeout_q, timeout_d;

  // Circular first-set search starting at ptr. The position is kept one bit
  // wider than an index so ptr+k can be folded back below N for any N.
  logic           found;
  logic [IDW-1:0] sel;
  logic [IDW:0]   pos;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr_q} + (IDW+1)'(k);
      if (pos >= (IDW+1)'(N)) pos = pos - (IDW+1)'(N);
      if (!found && req[pos[IDW-1:0]]) begin
        found = 1'b1;
        sel   = pos[IDW-1:0];
      end
    end
  end

  logic leave;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    leave     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d      = ST_GRANT;
          gnt_d        = '0;
          gnt_d[sel]   = 1'b1;
          gnt_id_d     = sel;
          busy_d       = 1'b1;
          cnt_d        = '0;
        end
      end
      ST_GRANT: begin
        // A dropped request wins over the hold limit, so a drop on the last
        // allowed cycle is a normal release without a timeout pulse.
        if (!req[gnt_id_q]) begin
          leave = 1'b1;
        end else if (MAX_HOLD != 0 && cnt_q == CNT_LAST) begin
          leave     = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (leave) begin
          state_d  = ST_RELEASE;
          gnt_d    = '0;
          gnt_id_d = '0;
          busy_d   = 1'b0;
          cnt_d    = '0;
          // The owner index is cleared from gnt_id here, so the pointer is
          // advanced now while the owner is still known.
          ptr_d    = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + IDW'(1);
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
        busy_d   = 1'b0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_mutex_arbiter.sv
module tb_rr_mutex_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int IDW      = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           timeout;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0]   eg;
  logic [IDW-1:0] ei;

  rr_mutex_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [N-1:0] xg, input logic [IDW-1:0] xi,
                     input logic xb, input logic xt);
    checks++;
    assert (gnt === xg) else begin
      failures++;
      $error("FAIL %s gnt observed=%b expected=%b", tag, gnt, xg);
    end
    checks++;
    assert (gnt_id === xi) else begin
      failures++;
      $error("FAIL %s gnt_id observed=%0d expected=%0d", tag, gnt_id, xi);
    end
    checks++;
    assert (busy === xb) else begin
      failures++;
      $error("FAIL %s busy observed=%b expected=%b", tag, busy, xb);
    end
    checks++;
    assert (timeout === xt) else begin
      failures++;
      $error("FAIL %s timeout observed=%b expected=%b", tag, timeout, xt);
    end
  endtask

  initial begin
    // Reset values, before any edge and while reset is held
    rst_n = 1'b0;
    req   = '0;
    #2;
    chk("rst_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    repeat (3) begin
      step();
      chk("rst_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("rst_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    end

    // Contention: all requesters from reset release, 8-cycle grants in order
    rst_n = 1'b0;
    req   = 4'b1111;
    step();
    chk("rst_with_req", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int g = 0; g < 5; g++) begin
      eg = 4'b0001 << (g % 4);
      ei = IDW'(g % 4);
      for (int c = 0; c < MAX_HOLD; c++) begin
        step();
        chk("rot_grant", eg, ei, 1'b1, 1'b0);
      end
      step();
      chk("rot_release", 4'b0000, 2'd0, 1'b0, 1'b1);
      step();
      chk("rot_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    end

    // Pointer now 1: index 2 beats index 0
    req = 4'b0101;
    step();
    chk("prio_ptr", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    chk("prio_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    chk("prio_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single request held for 5 grant cycles, then dropped
    req = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("single_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    req = 4'b0000;
    step();
    chk("single_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    chk("single_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Request drops on the same edge the hold limit would fire
    req = 4'b0010;
    for (int c = 0; c < MAX_HOLD; c++) begin
      step();
      chk("limit_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    req = 4'b0000;
    step();
    chk("drop_at_limit", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    chk("limit_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a grant to index 3
    req = 4'b1000;
    step();
    chk("pre_rst_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
    step();
    chk("pre_rst_hold", 4'b1000, 2'd3, 1'b1, 1'b0);
    #1;
    req   = 4'b1001;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    step();
    chk("post_rst_ptr0", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_mutex_arbiter.md
# rr_mutex_arbiter

Clocked round-robin arbiter that shares a single resource among N requesters with mutual-exclusion guarantees. It is the synchronous counterpart to the team's two-input mutual-exclusion element and sits between the requesting blocks and the shared resource. It adds fairness, a bounded hold time and a guaranteed dead cycle between successive owners.

## Interface
Parameters:
- N, 4: number of requesters; legal range 2–16.
- MAX_HOLD, 8: maximum consecutive cycles one grant may be held; 0 disables the timeout.
- IDW, $clog2(N): width of gnt_id (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N  request vector; req[i] is level-sensitive and held high for as long as requester i wants the resource.
- gnt  out  N  one-hot grant; all-zero when no one owns the resource.
- gnt_id  out  IDW  index of the current owner; 0 when gnt==0.
- busy  out  1  high while any gnt bit is high.
- timeout  out  1  one-cycle pulse when a grant is forcibly revoked by the hold limit.

## Operation
- Reset is asynchronous active-low, applied in one clock domain. While rst_n=0 the block holds:
  - gnt=0, gnt_id=0, busy=0, timeout=0;
  - state=IDLE, priority pointer ptr=0, hold counter cnt=0.
- All outputs are registered and change only on rising clk edges. The only exception is asynchronous reset assertion.
- The state machine has three states: IDLE, GRANT, RELEASE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first set bit of req, searching circularly from ptr upward: ptr, ptr+1, … wrapping N-1→0.
  - Load owner=selected, gnt=1<<owner, gnt_id=owner, busy=1, cnt=0, and go to GRANT.
- GRANT:
  - If req[owner]=0, go to RELEASE (normal release).
  - Else if MAX_HOLD≠0 and cnt==MAX_HOLD-1, go to RELEASE (forced release) and set timeout=1 for the RELEASE cycle.
  - Otherwise increment cnt and stay in GRANT.
  - Requests from other indices are ignored while in GRANT.
- RELEASE:
  - gnt=0, gnt_id=0, busy=0.
  - ptr = (owner+1) mod N.
  - Always go to IDLE on the next edge. No arbitration happens in RELEASE.
- Mutual exclusion: at most one gnt bit is high in any cycle. At least one all-zero gnt cycle separates two successive owners, including when the same index is regranted.
- After a forced release, the same requester may be regranted. It has lowest priority because ptr has advanced past it.
- The hold counter width is $clog2(MAX_HOLD+1). cnt never exceeds MAX_HOLD-1 and never wraps.
- Behaviour for N outside 2–16 is unspecified and is blocked by a synthesis-time check.

## Timing
- Grant latency: req sampled high in IDLE at edge E0 → gnt high in the cycle after E0. This is a 1-edge latency.
- Release latency: req[owner] sampled low at edge E1 → gnt low in the cycle after E1, which is the RELEASE cycle. The earliest next grant is visible after E1+2 edges.
- Hold bound: gnt for one owner is high for at most MAX_HOLD consecutive cycles. The timeout pulse coincides with the first gnt=0 cycle.
- Minimum handover period: 3 edges from release request to the next owner's gnt, i.e. GRANT→RELEASE→IDLE→GRANT.
- A req[owner] glitch low for one sampled edge ends the grant. There is no re-arm.
- Simultaneous drop of req[owner] and timeout at the same edge is a normal release: timeout stays 0.
- Reset asserted mid-GRANT: gnt drops to 0 immediately (asynchronously) and ptr returns to 0.
- Reset deassertion: the first arbitration happens at the first edge after rst_n rises.

## Test plan
Bench configuration: N=4, MAX_HOLD=8, 10 ns clock.
1. Reset values: during and after reset with req=0 → gnt=0000, gnt_id=0, busy=0, timeout=0 for 20 cycles.
2. Single request: req=0100 at edge E0, then dropped at E0+5.
   - gnt=0100 and gnt_id=2 from E0+1 through E0+5.
   - gnt=0000 after E0+5.
   - No timeout.
3. Contention and rotation: req=1111 held constantly from reset release.
   - Grants go in the order 0,1,2,3,0, each exactly 8 cycles.
   - A one-cycle timeout pulse follows each grant.
   - Every handover has exactly 2 gnt=0000 cycles.
4. Priority pointer: after owner 0 releases (ptr=1), apply req=0101 → gnt=0100 (index 2) is granted before index 0.
5. Drop coinciding with limit: req[1] drops exactly at the edge where cnt=7 → RELEASE with timeout=0.
6. Reset mid-grant: rst_n pulled low for 3 ns while gnt=1000.
   - gnt=0000 within the same cycle, without waiting for an edge.
   - After reset release with req=1001, gnt=0001 because ptr was reset to 0.
